// File: rtl/draw_scheduler_pkg.sv
// Shared display definitions for the draw engines and the plot-port scheduler:
// coordinate/colour widths, scheduler state encoding and a round-robin index helper.
package draw_scheduler_pkg;

    localparam int COORD_W  = 9;
    localparam int COLOUR_W = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } sched_state_t;

    // Index reached by stepping 'offset' places up from 'last', wrapping at n.
    function automatic int rr_index(input int last, input int offset, input int n);
        return (last + offset) % n;
    endfunction

endpackage

// File: rtl/draw_scheduler_rr_pick.sv
// Combinational round-robin selector: the first requester found searching upward
// from last_grant+1 (with wrap-around) wins.
module rr_pick
    import draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GID_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   last_grant,
    output logic [GID_W-1:0]   winner,
    output logic               valid
);

    logic [GID_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the engine gi+1 places after the previous winner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = GID_W'(rr_index(int'(last_grant), gi + 1, NUM_REQ));
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                winner = cand_idx[i];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates several draw engines onto one VGA plot port: round-robin grant,
// registered pixel forwarding while busy, one-cycle release and a busy watchdog.
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  TIMEOUT = 1024,
    localparam int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            eng_done,
    input  logic [NUM_REQ*COORD_W-1:0]    eng_x,
    input  logic [NUM_REQ*COORD_W-1:0]    eng_y,
    input  logic [NUM_REQ*COLOUR_W-1:0]   eng_colour,
    input  logic                          clr_err,
    output logic [NUM_REQ-1:0]            draw_en,
    output logic [COORD_W-1:0]            vga_x,
    output logic [COORD_W-1:0]            vga_y,
    output logic [COLOUR_W-1:0]           vga_colour,
    output logic                          plot,
    output logic                          busy,
    output logic [GID_W-1:0]              grant_id,
    output logic                          timeout_err
);

    sched_state_t         state_reg, state_next;
    logic [GID_W-1:0]     grant_reg, grant_next;
    logic [GID_W-1:0]     last_reg, last_next;
    logic [WD_W-1:0]      wdog_reg, wdog_next;
    logic                 err_reg, err_next;
    logic                 plot_reg, plot_next;
    logic [COORD_W-1:0]   x_reg, x_next, y_reg, y_next;
    logic [COLOUR_W-1:0]  col_reg, col_next;

    logic [GID_W-1:0]     pick_winner;
    logic                 pick_valid;
    logic                 granted_done;
    logic                 timeout_hit;

    logic [COORD_W-1:0]   x_arr   [NUM_REQ];
    logic [COORD_W-1:0]   y_arr   [NUM_REQ];
    logic [COLOUR_W-1:0]  col_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_eng
            assign x_arr[gi]   = eng_x[gi*COORD_W +: COORD_W];
            assign y_arr[gi]   = eng_y[gi*COORD_W +: COORD_W];
            assign col_arr[gi] = eng_colour[gi*COLOUR_W +: COLOUR_W];
            assign draw_en[gi] = (state_reg == S_BUSY) && (grant_reg == GID_W'(gi));
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GID_W   (GID_W)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_reg),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    assign granted_done = eng_done[grant_reg];
    assign timeout_hit  = (wdog_reg == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        wdog_next  = wdog_reg;
        err_next   = err_reg;
        plot_next  = 1'b0;
        x_next     = '0;
        y_next     = '0;
        col_next   = '0;

        if (clr_err) begin
            err_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (pick_valid) begin
                    state_next = S_BUSY;
                    grant_next = pick_winner;
                    wdog_next  = '0;
                end
            end
            S_BUSY: begin
                if (granted_done) begin
                    state_next = S_RELEASE;
                    last_next  = grant_reg;
                end else if (timeout_hit) begin
                    // Timeout overrides a simultaneous clr_err.
                    state_next = S_RELEASE;
                    last_next  = grant_reg;
                    err_next   = 1'b1;
                end else begin
                    // Pixel outputs only load while the grant persists, so they read 0 outside BUSY.
                    wdog_next = wdog_reg + 1'b1;
                    plot_next = 1'b1;
                    x_next    = x_arr[grant_reg];
                    y_next    = y_arr[grant_reg];
                    col_next  = col_arr[grant_reg];
                end
            end
            S_RELEASE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
            grant_reg <= '0;
            last_reg  <= GID_W'(NUM_REQ - 1);
            wdog_reg  <= '0;
            err_reg   <= 1'b0;
            plot_reg  <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            col_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
            wdog_reg  <= wdog_next;
            err_reg   <= err_next;
            plot_reg  <= plot_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            col_reg   <= col_next;
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign grant_id    = grant_reg;
    assign timeout_err = err_reg;
    assign plot        = plot_reg;
    assign vga_x       = x_reg;
    assign vga_y       = y_reg;
    assign vga_colour  = col_reg;

endmodule
